// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter: default geometry, the
// per-requester request record and the round-robin pick function.
package mem_arb_pkg;

    localparam int unsigned DefWidth   = 16;
    localparam int unsigned DefSize    = 64;
    localparam int unsigned DefLogsize = 6;
    localparam int unsigned MaxNreq    = 8;

    typedef struct packed {
        logic                  wr;
        logic [DefLogsize-1:0] addr;
        logic [DefWidth-1:0]   wdata;
    } mem_req_t;

    // One-hot grant: first asserted req at or after ptr, wrapping at nreq.
    function automatic logic [MaxNreq-1:0] rr_pick(input logic [MaxNreq-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned nreq);
        logic [MaxNreq-1:0] grant;
        int unsigned        idx;
        grant = '0;
        for (int unsigned k = 0; k < MaxNreq; k++) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) idx = idx - nreq;
                if (grant == '0 && req[idx]) grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter owning the priority pointer; the pointer moves past
// the granted requester whenever a grant is taken.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int unsigned PtrW = $clog2(NREQ);

    logic [PtrW-1:0]    prio_ptr_q, prio_ptr_d;
    logic [MaxNreq-1:0] req_ext, pick, unused_pick;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
        pick               = rr_pick(req_ext, 32'(prio_ptr_q), NREQ);
        // Bits above NREQ are always zero.
        unused_pick        = pick;
        grant              = reset_n ? pick[NREQ-1:0] : '0;
    end

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (advance && grant[i]) begin
                prio_ptr_d = (i == NREQ - 1) ? '0 : PtrW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) prio_ptr_q <= '0;
        else          prio_ptr_q <= prio_ptr_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between NREQ requesters with a
// round-robin grant and routes each read response back one cycle later.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned SIZE    = DefSize,
    parameter int unsigned LOGSIZE = DefLogsize,
    parameter int unsigned NREQ    = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ-1:0]                req_wr,
    input  logic [NREQ-1:0][LOGSIZE-1:0]   req_addr,
    input  logic [NREQ-1:0][WIDTH-1:0]     req_wdata,
    output logic [NREQ-1:0]                ready,
    output logic [NREQ-1:0]                rvalid,
    output logic [WIDTH-1:0]               rdata,
    output logic [LOGSIZE-1:0]             mem_addr,
    output logic                           mem_wr_en,
    output logic [WIDTH-1:0]               mem_data_in,
    input  logic [WIDTH-1:0]               mem_data_out
);

    localparam int unsigned IdW = $clog2(NREQ);
    // Addresses are passed through untouched; SIZE only documents the legal range.
    localparam bit unused_size_ok = SIZE <= (1 << LOGSIZE);

    logic           accept;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IdW-1:0] rsp_id_q, rsp_id_d;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .advance(accept),
        .grant  (ready)
    );

    // ready already implies req, so any grant is an accepted transfer.
    assign accept = |ready;

    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_wr_en   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ready[i]) begin
                mem_addr    = req_addr[i];
                mem_data_in = req_wdata[i];
                mem_wr_en   = req_wr[i];
                rsp_valid_d = !req_wr[i];
                rsp_id_d    = IdW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (reset_n && rsp_valid_q && rsp_id_q == IdW'(i)) rvalid[i] = 1'b1;
        end
    end

    // The memory's output register already provides the response timing.
    assign rdata = mem_data_out;

endmodule
